// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: sums the float32 elements of each input packet with an
// external single-precision adder and emits one sum plus element count per
// packet.
//
// The first element of a packet is loaded straight into the accumulator.
// Every later element is paired with the running sum and sent to the adder
// (load / result_ready / result_ack handshake). The adder's result becomes
// the new running sum.
//
// Optional build macro FP_ACCUM_ZERO_SKIP_EN: when defined, a non-first
// element equal to +0 or -0 leaves the sum unchanged and skips the adder.
//
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   in_*               element stream (valid/ready, in_last marks packet end)
//   add_*              adder interface (load pulse, operands, result handshake)
//   sum_*              per-packet result (valid/ready)
//
// state    | meaning
// IDLE     | waiting for the first element of a packet
// WAIT_IN  | waiting for the next element of the packet
// ISSUE    | one-cycle add_load pulse
// WAIT_RES | waiting for the adder's result_ready
// ACK      | acknowledging until result_ready falls
// OUT      | presenting sum/count until sum_ready

module fp_accum_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic             add_load,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_result,
  input  logic             add_result_ready,
  output logic             add_result_ack,
  output logic [31:0]      sum_data,
  output logic [CNT_W-1:0] sum_count,
  output logic             sum_valid,
  input  logic             sum_ready
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    ISSUE,
    WAIT_RES,
    ACK,
    OUT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_nxt;
  logic [31:0]      acc, acc_nxt;
  logic [31:0]      a_q, a_nxt;
  logic [31:0]      b_q, b_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             last_q, last_nxt;
  logic             accept;
  logic             zero_skip;

  // Gated by reset so the upstream never sees a ready while reset is held.
  assign in_ready = ((state == IDLE) || (state == WAIT_IN)) && !reset;
  assign accept   = in_valid && in_ready;

`ifdef FP_ACCUM_ZERO_SKIP_EN
  assign zero_skip = (in_data[30:0] == 31'd0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      acc    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cnt    <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      a_q    <= a_nxt;
      b_q    <= b_nxt;
      cnt    <= cnt_nxt;
      last_q <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    a_nxt     = a_q;
    b_nxt     = b_q;
    cnt_nxt   = cnt;
    last_nxt  = last_q;
    case (state)
      IDLE: begin
        if (accept) begin
          acc_nxt   = in_data;
          cnt_nxt   = CNT_ONE;
          state_nxt = in_last ? OUT : WAIT_IN;
        end
      end
      WAIT_IN: begin
        if (accept) begin
          // Count saturates; accumulation continues regardless.
          cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
          if (zero_skip) begin
            state_nxt = in_last ? OUT : WAIT_IN;
          end else begin
            a_nxt     = acc;
            b_nxt     = in_data;
            last_nxt  = in_last;
            state_nxt = ISSUE;
          end
        end
      end
      ISSUE: begin
        state_nxt = WAIT_RES;
      end
      WAIT_RES: begin
        if (add_result_ready) begin
          acc_nxt   = add_result;
          state_nxt = ACK;
        end
      end
      ACK: begin
        // Ack stays up until the adder withdraws result_ready, so a new load
        // can never overlap a pending result.
        if (!add_result_ready) begin
          state_nxt = last_q ? OUT : WAIT_IN;
        end
      end
      OUT: begin
        if (sum_ready) begin
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign add_load       = (state == ISSUE);
  assign add_result_ack = (state == ACK);
  assign add_a          = a_q;
  assign add_b          = b_q;
  assign sum_valid      = (state == OUT);
  assign sum_data       = sum_valid ? acc : 32'd0;
  assign sum_count      = sum_valid ? cnt : '0;

endmodule

// File: tb/tb_fp_accum_ctrl.sv
module tb_fp_accum_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in_data;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic          add_load;
  logic [31:0]   add_a;
  logic [31:0]   add_b;
  logic [31:0]   add_result;
  logic          add_result_ready;
  logic          add_result_ack;
  logic [31:0]   sum_data;
  logic [CW-1:0] sum_count;
  logic          sum_valid;
  logic          sum_ready;

  fp_accum_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_load(add_load), .add_a(add_a), .add_b(add_b),
    .add_result(add_result), .add_result_ready(add_result_ready),
    .add_result_ack(add_result_ack),
    .sum_data(sum_data), .sum_count(sum_count), .sum_valid(sum_valid),
    .sum_ready(sum_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // float32 <-> real for normal numbers and zero (enough for integer values)
  function automatic real f2r(input logic [31:0] f);
    real r;
    int  e;
    if (f[30:0] == 31'd0) return 0.0;
    r = 1.0 + real'(f[22:0]) / 8388608.0;
    e = int'(f[30:23]) - 127;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return f[31] ? -r : r;
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int          e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = int'(d[62:52]) - 1023 + 127;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Behavioural adder: result after `lat` cycles, result_ready held until
  // `hold` acked edges have been seen.
  int lat = 1;
  int hold = 1;
  int lat_cnt;
  int seen;
  logic busy;
  logic [31:0] ra, rb;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      add_result_ready <= 1'b0;
      add_result       <= 32'd0;
      busy             <= 1'b0;
      lat_cnt          <= 0;
      seen             <= 0;
    end else if (add_load) begin
      busy    <= 1'b1;
      lat_cnt <= lat - 1;
      ra      <= add_a;
      rb      <= add_b;
    end else if (busy && !add_result_ready) begin
      if (lat_cnt == 0) begin
        add_result_ready <= 1'b1;
        add_result       <= r2f(f2r(ra) + f2r(rb));
        seen             <= 0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end else if (add_result_ready && add_result_ack) begin
      if (seen >= hold - 1) begin
        add_result_ready <= 1'b0;
        busy             <= 1'b0;
      end else begin
        seen <= seen + 1;
      end
    end
  end

  // Protocol monitor
  int load_cnt = 0;
  int ack_cycles = 0;
  logic [31:0] cap_a = 0, cap_b = 0;
  logic p_ack = 0, p_rr = 0;

  always @(negedge clk) begin
    if (!reset) begin
      if (add_load) begin
        load_cnt++;
        chk("load_overlap", {add_result_ack, add_result_ready}, 0);
        cap_a = add_a;
        cap_b = add_b;
      end else if (busy || add_result_ack) begin
        chk("add_a_stable", add_a, cap_a);
        chk("add_b_stable", add_b, cap_b);
      end
      if (p_ack && p_rr) chk("ack_hold", add_result_ack, 1);
      if (add_result_ack) ack_cycles++;
    end
    p_ack = add_result_ack;
    p_rr  = add_result_ready;
  end

  logic [31:0] pkt_buf[0:15];
  int pkt_len;

  // Returns just after the posedge that accepts the last element.
  task automatic send_pkt();
    for (int i = 0; i < pkt_len; i++) begin
      int t;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = pkt_buf[i];
      in_last  = (i == pkt_len - 1);
      t = 0;
      while (!in_ready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) chk("in_ready_timeout", in_ready, 1);
      @(posedge clk);
    end
  endtask

  // waited = 0 means sum_valid was high one cycle after the last acceptance.
  task automatic get_sum(input int rdelay, output logic [31:0] d, output int c,
                         output int waited);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    waited   = 0;
    while (!sum_valid && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!sum_valid) chk("sum_valid_timeout", sum_valid, 1);
    d = sum_data;
    c = int'(sum_count);
    for (int k = 0; k < rdelay; k++) begin
      @(negedge clk);
      chk("sum_hold_data", sum_data, d);
      chk("sum_hold_valid", sum_valid, 1);
    end
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_ctrl"}, {in_ready, add_load, add_result_ack, sum_valid}, 0);
    chk({name, "_add_a"}, add_a, 0);
    chk({name, "_add_b"}, add_b, 0);
    chk({name, "_sum"}, {sum_data, sum_count}, 0);
  endtask

  typedef struct {
    int          n;
    logic [31:0] e0, e1, e2;
    logic [31:0] exp_sum;
    int          exp_cnt;
    int          exp_loads;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [31:0] d;
    int c, w, l0, a0, skip_loads;

`ifdef FP_ACCUM_ZERO_SKIP_EN
    skip_loads = 0;
`else
    skip_loads = 1;
`endif
    vt[0] = '{2, 32'h42480000, 32'h00000000, 0, 32'h42480000, 2, skip_loads, 5, 1};
    vt[1] = '{2, 32'h41880000, 32'h41100000, 0, 32'h41D00000, 2, 1, 3, 1};
    vt[2] = '{3, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40C00000, 3, 2, 2, 4};
    vt[3] = '{1, 32'hC0A00000, 0, 0, 32'hC0A00000, 1, 0, 1, 1};
    vt[4] = '{2, 32'h40000000, 32'h40000000, 0, 32'h40800000, 2, 1, 1, 1};

    reset = 1'b1; in_valid = 1'b0; in_data = 0; in_last = 1'b0; sum_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    #1 chk("ready_after_reset", in_ready, 1);

    for (int i = 0; i < 5; i++) begin
      pkt_buf[0] = vt[i].e0; pkt_buf[1] = vt[i].e1; pkt_buf[2] = vt[i].e2;
      pkt_len = vt[i].n;
      lat = vt[i].lat; hold = vt[i].hold;
      l0 = load_cnt; a0 = ack_cycles;
      send_pkt();
      get_sum(0, d, c, w);
      chk($sformatf("vec%0d_sum", i), d, vt[i].exp_sum);
      chk($sformatf("vec%0d_cnt", i), c, vt[i].exp_cnt);
      chk($sformatf("vec%0d_loads", i), load_cnt - l0, vt[i].exp_loads);
      if (vt[i].exp_loads == 0) chk($sformatf("vec%0d_latency", i), w, 0);
      if (i == 1) begin
        chk("vec1_add_a", cap_a, 32'h41880000);
        chk("vec1_add_b", cap_b, 32'h41100000);
      end
      if (i == 2) chk("vec2_ack_len", (ack_cycles - a0) >= 2 * vt[i].hold, 1);
    end

    // Random packets against an arithmetic reference
    for (int p = 0; p < 25; p++) begin
      real ref_sum;
      int  n;
      n = $urandom_range(1, 5);
      ref_sum = 0.0;
      for (int k = 0; k < n; k++) begin
        int v;
        v = int'($urandom_range(0, 32)) - 16;
        pkt_buf[k] = r2f(real'(v));
        ref_sum = ref_sum + real'(v);
      end
      pkt_len = n;
      lat = $urandom_range(1, 6);
      hold = $urandom_range(1, 3);
      send_pkt();
      get_sum($urandom_range(0, 3), d, c, w);
      chk($sformatf("rand%0d_sum", p), d, r2f(ref_sum));
      chk($sformatf("rand%0d_cnt", p), c, n);
    end

    // Count saturation at 2^CW-1 while the sum keeps accumulating
    lat = 1; hold = 1;
    for (int k = 0; k < 9; k++) pkt_buf[k] = 32'h3F800000;
    pkt_len = 9;
    send_pkt();
    get_sum(0, d, c, w);
    chk("sat_sum", d, 32'h41100000);
    chk("sat_cnt", c, 7);

    // Output backpressure with the next element already offered
    pkt_buf[0] = 32'h40400000; pkt_len = 1;
    send_pkt();
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h40A00000; in_last = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", sum_valid, 1);
      chk("bp_data", sum_data, 32'h40400000);
      chk("bp_cnt", sum_count, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    sum_ready = 1'b1;
    @(posedge clk);
    #1 sum_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_valid", sum_valid, 0);
    chk("bp_idle_ready", in_ready, 1);
    @(posedge clk);
    get_sum(0, d, c, w);
    chk("bp_next_sum", d, 32'h40A00000);
    chk("bp_next_cnt", c, 1);
    chk("bp_next_latency", w, 0);

    // Reset while waiting on the adder
    lat = 20; hold = 1;
    pkt_buf[0] = 32'h3F800000; pkt_buf[1] = 32'h40000000; pkt_len = 2;
    send_pkt();
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {busy, add_load, add_result_ready}, 3'b100);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    lat = 2;
    pkt_buf[0] = 32'h40000000; pkt_buf[1] = 32'h40000000; pkt_len = 2;
    send_pkt();
    get_sum(0, d, c, w);
    chk("post_reset_sum", d, 32'h40800000);
    chk("post_reset_cnt", c, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_accum_ctrl.md
Name: fp_accum_ctrl

Overview:
- Downstream/control stage wrapped around the single-precision FP adder (load / Number1 / Number2 / result_ack / Result / result_ready handshake).
- Accepts a packet stream of IEEE-754 float32 values and issues one adder operation per element after the first, feeding each result back as the running sum.
- Emits one float32 sum plus an element count per packet on a valid/ready output.

Parameters:
- CNT_W, 16, width of the per-packet element counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- in_data  in  32  float32 element
- in_valid  in  1  in_data is valid
- in_last  in  1  marks the final element of a packet; qualified by in_valid
- in_ready  out  1  controller can accept an element
- add_load  out  1  one-cycle pulse to the adder's load
- add_a  out  32  to adder Number1; carries the running sum
- add_b  out  32  to adder Number2; carries the new element
- add_result  in  32  from adder Result
- add_result_ready  in  1  from adder result_ready
- add_result_ack  out  1  to adder result_ack
- sum_data  out  32  packet sum
- sum_count  out  CNT_W  number of elements accepted in the packet
- sum_valid  out  1  sum_data and sum_count are valid
- sum_ready  in  1  consumer accepts the sum

Behaviour:
- Reset values:
  - State = IDLE.
  - acc = 0 and cnt = 0.
  - All outputs are 0, including in_ready, add_load, add_result_ack and sum_valid.
  - add_a, add_b, sum_data and sum_count are 0.
- in_ready is 1 only in IDLE and WAIT_IN, and is 0 while reset is asserted. An element is accepted on a clock edge where in_valid & in_ready.
- IDLE:
  - Accept: acc <= in_data and cnt <= 1. No adder operation is issued for the first element.
  - If in_last is 1, go to OUT. Otherwise go to WAIT_IN.
- WAIT_IN:
  - Accept: add_a <= acc, add_b <= in_data, cnt <= sat(cnt+1), and the in_last flag is latched.
  - Go to ISSUE.
- ISSUE:
  - add_load = 1 for exactly one cycle.
  - Go to WAIT_RES.
- WAIT_RES:
  - Wait with no timeout.
  - On add_result_ready = 1: acc <= add_result, assert add_result_ack, go to ACK.
- ACK:
  - Hold add_result_ack = 1 until add_result_ready is sampled 0, then drop ack.
  - Go to OUT if the latched last flag is 1, otherwise go to WAIT_IN.
  - add_result_ack is high for at least 1 cycle.
  - A new add_load is never issued while add_result_ack or add_result_ready is high.
- OUT:
  - sum_valid = 1, sum_data = acc, sum_count = cnt.
  - All three are held stable until sum_valid & sum_ready on a clock edge.
  - Then acc <= 0, cnt <= 0, go to IDLE.
  - in_ready = 0 throughout OUT, so no overlap with the next packet.
- Latency:
  - Single-element packet: sum_valid rises 1 cycle after acceptance.
  - Each further element costs 1 (ISSUE) + adder latency + ack cycles before in_ready returns.
- add_a and add_b are registered and stay stable from ISSUE through ACK.
- in_last is ignored when in_valid = 0.
- Element count saturation: cnt stops at 2^CNT_W-1 and accumulation continues.
- Arithmetic: no float math is done in this block. NaN, Inf and denormals pass through the adder unchanged in meaning.
- Reset mid-operation (any state):
  - Return to IDLE immediately and discard the partial sum.
  - add_load and add_result_ack drop asynchronously.
  - The adder shares the same system reset.
- Simultaneous sum_ready and a new in_valid in OUT: the sum handshake completes; the element is not accepted until the IDLE cycle that follows.

Optional Feature:
- Macro: FP_ACCUM_ZERO_SKIP_EN.
- Defined: in WAIT_IN, an accepted element whose bits[30:0] == 0 (+0 or -0) does not go through the adder.
  - acc is unchanged and cnt still increments.
  - Next state is OUT if in_last, otherwise WAIT_IN; no add_load is pulsed.
- Undefined: every non-first element goes through ISSUE/WAIT_RES/ACK, zeros included.
- The first element always bypasses the adder in both builds.

Test Plan:
- Packet {0x42480000, 0x00000000 last} with a behavioural adder of 5-cycle latency -> sum_data = 0x42480000, sum_count = 2, exactly one add_load pulse. With FP_ACCUM_ZERO_SKIP_EN there are zero add_load pulses and sum_valid rises 1 cycle after the second element is accepted.
- Packet {0x41880000, 0x41100000 last} (17+9) -> sum_data = 0x41D00000 (26.0), sum_count = 2, add_a = 0x41880000 and add_b = 0x41100000 stable from ISSUE through ACK.
- Packet {0x3F800000, 0x40000000, 0x40400000 last} with the adder holding result_ready for 3 cycles after ack -> sum_data = 0x40C00000 (6.0), sum_count = 3, add_result_ack held until result_ready = 0, two add_load pulses total.
- Single element 0xC0A00000 with in_last = 1 -> sum_valid rises the next cycle, sum_data = 0xC0A00000, sum_count = 1, no add_load pulse.
- Output backpressure: sum_ready = 0 for 6 cycles with in_valid = 1 -> sum_valid stays 1, sum_data and sum_count stay constant, in_ready stays 0. After sum_ready = 1 the next element is accepted in IDLE and the next sum is correct.
- Assert reset for 1 cycle while in WAIT_RES -> all outputs 0 in the same cycle. Next packet {0x40000000, 0x40000000 last} -> 0x40800000, sum_count = 2, with no residue from the aborted packet.
